// File: rtl/rapids_fetch.sv
// rapids instruction fetch stage: PC, mmu read issue, in-order
// instruction queue toward decode, go/halt/redirect control.
module rapids_fetch #(
  parameter int              PC_W     = 16,
  parameter int              DATA_W   = 32,
  parameter int              DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              go,
  input  logic              halt,
  output logic              mem_req,
  output logic [PC_W-1:0]   mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              running
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop;
  logic [CW-1:0]     occ;
  logic [CW:0]       used;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   fetch_pc;
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PC_W-1:0]   q_pc   [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic              active;
  logic              flush;
  logic              start;
  logic              issue;
  logic              push;
  logic              pop;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign active = (state != IDLE);
  assign flush  = redirect & active;
  assign start  = (state == IDLE) & go;
  assign used   = {1'b0, outstanding} + {1'b0, occ};
  assign issue  = mem_req & mem_gnt;
  // returns owed to a pre-redirect stream never reach the queue
  assign push   = mem_rvalid & (drop == '0) & ~flush;
  assign pop    = inst_valid & inst_ready & ~flush;

  assign mem_addr   = pc;
  assign inst_valid = (occ != '0);
  assign inst       = q_data[rd_ptr];
  assign inst_pc    = q_pc[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset_n) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == IDLE):  if (go) state_nx = RUN;
      (state == RUN):   if (halt) state_nx = DRAIN;
      (state == DRAIN): if (outstanding == '0) state_nx = IDLE;
      default:          state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    running = 1'b0;
    unique case (1'b1)
      (state == RUN): begin
        running = 1'b1;
        mem_req = ~halt & ~redirect &
                  (used < (CW + 1)'(DEPTH));
      end
      (state == DRAIN): running = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      pc          <= RESET_PC;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(mem_rvalid);
      if (flush)
        drop <= outstanding - CW'(mem_rvalid);
      else if (mem_rvalid && drop != '0)
        drop <= drop - CW'(1);
      if (start)      pc <= RESET_PC;
      else if (flush) pc <= redirect_pc;
      else if (issue) pc <= pc + PC_W'(1);
      if (start)      fetch_pc <= RESET_PC;
      else if (flush) fetch_pc <= redirect_pc;
      else if (push)  fetch_pc <= fetch_pc + PC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= RESET_PC;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        q_data[wr_ptr] <= mem_rdata;
        q_pc[wr_ptr]   <= fetch_pc;
        wr_ptr         <= inc(wr_ptr);
      end
      if (pop) rd_ptr <= inc(rd_ptr);
      occ <= occ + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_rapids_fetch.sv
// Scoreboard bench for rapids_fetch: mmu model with selectable
// latency, expected stream queue, plus a PC_W=4 instance for wrap.
module tb_rapids_fetch;

  localparam int PW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          go;
  logic          halt;
  logic          mem_gnt;
  logic          inst_ready;
  logic          redirect;
  logic [PW-1:0] redirect_pc;
  logic          mem_req;
  logic [PW-1:0] mem_addr;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          inst_valid;
  logic [DW-1:0] inst;
  logic [PW-1:0] inst_pc;
  logic          running;

  logic          w_req;
  logic [3:0]    w_addr;
  logic          w_rvalid;
  logic [DW-1:0] w_rdata;
  logic          w_valid;
  logic [DW-1:0] w_inst;
  logic [3:0]    w_pc;
  logic          w_redirect;
  logic [3:0]    w_redirect_pc;
  logic          w_running;

  typedef struct {
    int          pc;
    logic [31:0] d;
  } exp_t;

  exp_t q[$];
  exp_t wq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   lat = 1;
  int   issued;

  always #5 clk = ~clk;

  rapids_fetch #(.PC_W(PW), .DATA_W(DW), .DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .halt(halt),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .running(running)
  );

  rapids_fetch #(.PC_W(4), .DATA_W(DW), .DEPTH(2)) dut_w (
    .clk(clk), .reset_n(reset_n), .go(go), .halt(halt),
    .mem_req(w_req), .mem_addr(w_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(w_rvalid), .mem_rdata(w_rdata),
    .inst_valid(w_valid), .inst(w_inst), .inst_pc(w_pc),
    .inst_ready(inst_ready), .redirect(w_redirect),
    .redirect_pc(w_redirect_pc), .running(w_running)
  );

  function automatic logic [31:0] memw(input logic [15:0] a);
    case (a)
      16'd0:   return 32'h9EF1_0004;
      16'd1:   return 32'h9EF2_0006;
      16'd2:   return 32'h8080_1020;
      16'd3:   return 32'h9EF3_0040;
      16'd4:   return 32'h213F_0000;
      16'd5:   return 32'h143F_0000;
      default: return 32'h5A00_0000 | {16'h0, a};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // fixed-latency in-order mmu for the main instance
  logic [3:0]    pv;
  logic [PW-1:0] pa [4];
  always @(posedge clk) begin
    if (reset_n) begin
      pv <= '0;
      for (int i = 0; i < 4; i++) pa[i] <= '0;
    end else begin
      pv    <= {pv[2:0], mem_req & mem_gnt};
      pa[0] <= mem_addr;
      pa[1] <= pa[0];
      pa[2] <= pa[1];
      pa[3] <= pa[2];
    end
  end
  assign mem_rvalid = pv[lat-1];
  assign mem_rdata  = memw(pa[lat-1]);

  logic       wv;
  logic [3:0] wa;
  always @(posedge clk) begin
    if (reset_n) begin
      wv <= 1'b0;
      wa <= '0;
    end else begin
      wv <= w_req & mem_gnt;
      wa <= w_addr;
    end
  end
  assign w_rvalid = wv;
  assign w_rdata  = memw({12'h0, wa});

  always @(posedge clk) begin
    if (reset_n)                 issued <= 0;
    else if (mem_req && mem_gnt) issued <= issued + 1;
  end

  // pops happen on the next rising edge, so sample the handshake now
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n && inst_valid && inst_ready &&
        !(redirect && running) && q.size() > 0) begin
      e = q.pop_front();
      chk("pc", 64'(inst_pc), 64'(e.pc));
      chk("inst", 64'(inst), 64'(e.d));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n && w_valid && inst_ready &&
        !(w_redirect && w_running) && wq.size() > 0) begin
      e = wq.pop_front();
      chk("w_pc", 64'(w_pc), 64'(e.pc));
      chk("w_inst", 64'(w_inst), 64'(e.d));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n    = 1'b1;
    go         = 1'b0;
    halt       = 1'b0;
    redirect   = 1'b0;
    w_redirect = 1'b0;
    tick(1);
    reset_n = 1'b0;
    q.delete();
    wq.delete();
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick(1);
    go = 1'b0;
  endtask

  task automatic push_exp(input int pc, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc = (pc + i) & 16'hFFFF;
      e.d  = memw(16'(pc + i));
      q.push_back(e);
    end
  endtask

  task automatic wait_empty(input string tag, input bit w,
                            input int budget);
    int n = 0;
    while ((w ? wq.size() : q.size()) > 0 && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, 64'(w ? wq.size() : q.size()), 64'd0);
  endtask

  task automatic stop_run(input string tag);
    int n = 0;
    halt = 1'b1;
    while ((running || w_running) && n < 30) begin
      tick(1);
      n++;
    end
    halt = 1'b0;
    chk(tag, 64'(running), 64'd0);
  endtask

  initial begin
    int   n;
    exp_t e;
    mem_gnt       = 1'b1;
    inst_ready    = 1'b1;
    redirect_pc   = '0;
    w_redirect_pc = '0;
    do_reset();

    @(negedge clk);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_valid", 64'(inst_valid), 64'd0);
    chk("rst_run", 64'(running), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_pc", 64'(inst_pc), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    tick(1);

    // basic stream
    push_exp(0, 6);
    pulse_go();
    @(negedge clk);
    chk("lat0", 64'(inst_valid), 64'd0);
    @(negedge clk);
    chk("lat1", 64'(inst_valid), 64'd0);
    @(negedge clk);
    chk("lat2", 64'(inst_valid), 64'd1);
    chk("lat2_pc", 64'(inst_pc), 64'd0);
    tick(1);
    wait_empty("basic_drain", 1'b0, 40);
    stop_run("basic_stop");

    // backpressure
    do_reset();
    inst_ready = 1'b0;
    push_exp(0, 8);
    pulse_go();
    n = 0;
    while (!inst_valid && n < 20) begin
      tick(1);
      n++;
    end
    chk("bp_first", 64'(inst_valid), 64'd1);
    tick(5);
    chk("bp_req", 64'(mem_req), 64'd0);
    chk("bp_pc", 64'(inst_pc), 64'd0);
    chk("bp_inst", 64'(inst), 64'(memw(16'd0)));
    inst_ready = 1'b1;
    wait_empty("bp_drain", 1'b0, 60);
    stop_run("bp_stop");

    // redirect with two requests in flight (3-cycle mmu)
    do_reset();
    lat = 3;
    pulse_go();
    tick(2);
    chk("rd_credit", 64'(mem_req), 64'd0);
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    push_exp(16'h40, 3);
    tick(1);
    redirect = 1'b0;
    wait_empty("rd_drain", 1'b0, 60);
    stop_run("rd_stop");

    // halt after three grants
    do_reset();
    lat = 1;
    push_exp(0, 3);
    pulse_go();
    n = 0;
    while (issued < 3 && n < 20) begin
      tick(1);
      n++;
    end
    chk("h_issued3", 64'(issued), 64'd3);
    halt       = 1'b1;
    inst_ready = 1'b0;
    @(negedge clk);
    chk("h_req", 64'(mem_req), 64'd0);
    chk("h_run", 64'(running), 64'd1);
    n = 0;
    while (running && n < 20) begin
      tick(1);
      n++;
    end
    chk("h_idle", 64'(running), 64'd0);
    chk("h_issued", 64'(issued), 64'd3);
    chk("h_keep", 64'(inst_valid), 64'd1);
    chk("h_keep_pc", 64'(inst_pc), 64'd2);
    halt       = 1'b0;
    inst_ready = 1'b1;
    wait_empty("h_drain", 1'b0, 10);
    @(negedge clk);
    chk("h_empty", 64'(inst_valid), 64'd0);
    tick(1);

    // reset with a full queue, then restart
    do_reset();
    inst_ready = 1'b0;
    pulse_go();
    tick(6);
    chk("rm_full", 64'(inst_valid), 64'd1);
    chk("rm_req0", 64'(mem_req), 64'd0);
    do_reset();
    @(negedge clk);
    chk("rm_valid", 64'(inst_valid), 64'd0);
    chk("rm_req", 64'(mem_req), 64'd0);
    chk("rm_run", 64'(running), 64'd0);
    tick(1);
    inst_ready = 1'b1;
    push_exp(0, 3);
    pulse_go();
    wait_empty("rm_restart", 1'b0, 30);
    stop_run("rm_stop");

    // PC wrap on the 4-bit instance
    do_reset();
    for (int i = 0; i < 4; i++) begin
      e.pc = (14 + i) & 15;
      e.d  = memw(16'(e.pc));
      wq.push_back(e);
    end
    pulse_go();
    w_redirect    = 1'b1;
    w_redirect_pc = 4'hE;
    tick(1);
    w_redirect = 1'b0;
    wait_empty("wrap_drain", 1'b1, 40);
    stop_run("wrap_stop");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
